// File: rtl/act_wei_loader.sv
// act_wei_loader: replays one weight+activation tile from a ready/valid beat stream onto the mem_controller write ports, then pulses start.
// Writes appear one cycle after beat acceptance; in_ready drops while serialising weights. Optional ACT_WEI_LOADER_WEI_SKIP_EN drops zero-flag weights.
module act_wei_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int IF_WIDTH    = 16,
    parameter int KERNEL_SIZE = 9,
    parameter int START_GAP   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_req,
    input  logic                           cfg_mode,
    input  logic                           in_valid,
    input  logic [IF_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic                           in_ready,
    output logic                           wr_req_wei_flag,
    output logic [KERNEL_SIZE-1:0]         wr_data_wei_flag,
    output logic                           wr_req_wei,
    output logic [DATA_WIDTH-1:0]          wr_data_wei,
    output logic                           wr_req_act_flag,
    output logic [IF_WIDTH-1:0]            wr_data_act_flag,
    output logic [IF_WIDTH-1:0]            wr_req_act,
    output logic [IF_WIDTH*DATA_WIDTH-1:0] wr_data_act,
    output logic                           mode,
    output logic                           start,
    output logic                           busy
);
    localparam int WEI_BEATS = (KERNEL_SIZE + IF_WIDTH - 1) / IF_WIDTH;
    localparam int LANE_W    = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;
    localparam int BEAT_W    = (WEI_BEATS > 1) ? $clog2(WEI_BEATS) : 1;
    localparam int BUS_W     = IF_WIDTH * DATA_WIDTH;
    localparam int PAD_W     = WEI_BEATS * IF_WIDTH;
    localparam logic [PAD_W-1:0] RANGE_PAD = (PAD_W'(1) << KERNEL_SIZE) - PAD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WFLAG, S_WLOAD, S_WSER, S_AFLAG, S_ADATA, S_GAP, S_START
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d, mode_q, mode_d;
    logic                   in_ready_q, in_ready_d, start_q, start_d;
    logic                   wflag_vld_q, wflag_vld_d;
    logic [KERNEL_SIZE-1:0] wflag_q, wflag_d;
    logic                   wei_vld_q, wei_vld_d;
    logic [DATA_WIDTH-1:0]  wei_q, wei_d;
    logic                   aflag_vld_q, aflag_vld_d;
    logic [IF_WIDTH-1:0]    aflag_q, aflag_d;
    logic [IF_WIDTH-1:0]    act_en_q, act_en_d;
    logic [IF_WIDTH-1:0]    aflag_buf_q, aflag_buf_d;
    logic [BUS_W-1:0]       act_q, act_d;
    logic [BUS_W-1:0]       wbuf_q, wbuf_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [LANE_W-1:0]      row_q, row_d;
    logic [3:0]             gap_q, gap_d;

    logic                   accept;
    logic                   last_beat;
    logic [IF_WIDTH-1:0]    lane_mask;
    logic [LANE_W:0]        nxt_lane;
    logic [DATA_WIDTH-1:0]  lane_sel;

    // Returns {found, lane} for the lowest set bit of m at or above lane 'from'.
    function automatic logic [LANE_W:0] first_lane(input logic [IF_WIDTH-1:0] m, input int from);
        logic [LANE_W:0] r;
        r = '0;
        for (int l = IF_WIDTH - 1; l >= 0; l--) begin
            if (m[l] && (l >= from)) r = {1'b1, LANE_W'(l)};
        end
        return r;
    endfunction

    assign accept    = in_valid && in_ready_q;
    assign last_beat = (int'(beat_q) == WEI_BEATS - 1);

`ifdef ACT_WEI_LOADER_WEI_SKIP_EN
    logic [PAD_W-1:0] wflag_pad;
    assign wflag_pad = PAD_W'(wflag_q);
`endif

    // Lanes of the current weight beat that produce a write.
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < WEI_BEATS; b++) begin
            if (int'(beat_q) == b) begin
                lane_mask = RANGE_PAD[b*IF_WIDTH +: IF_WIDTH];
`ifdef ACT_WEI_LOADER_WEI_SKIP_EN
                lane_mask = lane_mask & wflag_pad[b*IF_WIDTH +: IF_WIDTH];
`endif
            end
        end
    end

    assign nxt_lane = first_lane(lane_mask, (state_q == S_WSER) ? int'(lane_q) + 1 : 0);

    always_comb begin
        lane_sel = '0;
        for (int l = 0; l < IF_WIDTH; l++) begin
            if (lane_q == LANE_W'(l)) lane_sel = wbuf_q[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        mode_d      = mode_q;
        start_d     = 1'b0;
        wflag_vld_d = 1'b0;
        wflag_d     = wflag_q;
        wei_vld_d   = 1'b0;
        wei_d       = wei_q;
        aflag_vld_d = 1'b0;
        aflag_d     = aflag_q;
        act_en_d    = '0;
        act_d       = act_q;
        wbuf_d      = wbuf_q;
        aflag_buf_d = aflag_buf_q;
        beat_d      = beat_q;
        lane_d      = lane_q;
        row_d       = row_q;
        gap_d       = gap_q;
        if (start_q) busy_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_req && !busy_q) begin
                    mode_d  = cfg_mode;
                    busy_d  = 1'b1;
                    beat_d  = '0;
                    row_d   = '0;
                    gap_d   = '0;
                    state_d = S_WFLAG;
                end
            end
            S_WFLAG: begin
                if (accept) begin
                    wflag_vld_d = 1'b1;
                    wflag_d     = in_data[KERNEL_SIZE-1:0];
                    state_d     = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (accept) begin
                    wbuf_d = in_data;
                    // A beat with no lane to write costs no serialisation cycle.
                    if (nxt_lane[LANE_W]) begin
                        lane_d  = nxt_lane[LANE_W-1:0];
                        state_d = S_WSER;
                    end else if (last_beat) begin
                        state_d = S_AFLAG;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_WLOAD;
                    end
                end
            end
            S_WSER: begin
                wei_vld_d = 1'b1;
                wei_d     = lane_sel;
                if (nxt_lane[LANE_W]) begin
                    lane_d = nxt_lane[LANE_W-1:0];
                end else if (last_beat) begin
                    state_d = S_AFLAG;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = S_WLOAD;
                end
            end
            S_AFLAG: begin
                if (accept) begin
                    aflag_buf_d = in_data[IF_WIDTH-1:0];
                    state_d     = S_ADATA;
                end
            end
            S_ADATA: begin
                if (accept) begin
                    aflag_vld_d = 1'b1;
                    aflag_d     = aflag_buf_q;
                    act_en_d    = aflag_buf_q;
                    act_d       = in_data;
                    if (row_q == LANE_W'(IF_WIDTH - 1)) begin
                        gap_d   = '0;
                        state_d = (START_GAP == 0) ? S_START : S_GAP;
                    end else begin
                        row_d   = row_q + LANE_W'(1);
                        state_d = S_AFLAG;
                    end
                end
            end
            S_GAP: begin
                if (int'(gap_q) >= START_GAP - 1) state_d = S_START;
                else gap_d = gap_q + 4'd1;
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_WFLAG) || (state_d == S_WLOAD) ||
                     (state_d == S_AFLAG) || (state_d == S_ADATA);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            wflag_vld_q <= 1'b0;
            wflag_q     <= '0;
            wei_vld_q   <= 1'b0;
            wei_q       <= '0;
            aflag_vld_q <= 1'b0;
            aflag_q     <= '0;
            act_en_q    <= '0;
            act_q       <= '0;
            wbuf_q      <= '0;
            aflag_buf_q <= '0;
            beat_q      <= '0;
            lane_q      <= '0;
            row_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            wflag_vld_q <= wflag_vld_d;
            wflag_q     <= wflag_d;
            wei_vld_q   <= wei_vld_d;
            wei_q       <= wei_d;
            aflag_vld_q <= aflag_vld_d;
            aflag_q     <= aflag_d;
            act_en_q    <= act_en_d;
            act_q       <= act_d;
            wbuf_q      <= wbuf_d;
            aflag_buf_q <= aflag_buf_d;
            beat_q      <= beat_d;
            lane_q      <= lane_d;
            row_q       <= row_d;
            gap_q       <= gap_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign wr_req_wei_flag  = wflag_vld_q;
    assign wr_data_wei_flag = wflag_q;
    assign wr_req_wei       = wei_vld_q;
    assign wr_data_wei      = wei_q;
    assign wr_req_act_flag  = aflag_vld_q;
    assign wr_data_act_flag = aflag_q;
    assign wr_req_act       = act_en_q;
    assign wr_data_act      = act_q;
    assign mode             = mode_q;
    assign start            = start_q;
    assign busy             = busy_q;

endmodule

// File: doc/act_wei_loader.md
Name: act_wei_loader

Overview:
- Upstream feeder for mem_controller.
- Accepts one tile per load request as a beat stream on a ready/valid bus:
  - weight flag, then packed weights, then per-row activation flag and activation data.
- Replays the tile onto the mem_controller write ports: wr_req_*/wr_data_* for weight flag, weights, act flag and act data.
- Pulses start once the whole tile is written, then returns to idle.

Parameters:
DATA_WIDTH, 8, width of one activation/weight element
IF_WIDTH, 16, activation lanes per row and number of rows per tile
KERNEL_SIZE, 9, weights per tile; also the weight-flag width
START_GAP, 2, idle cycles between last act write and start pulse (0..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
load_req  in  1  one-cycle pulse that begins a tile load; ignored while busy
cfg_mode  in  1  mode for this tile; sampled at accepted load_req
in_valid  in  1  input beat valid
in_data  in  IF_WIDTH*DATA_WIDTH  input beat; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  out  1  beat accepted when in_valid && in_ready
wr_req_wei_flag  out  1  weight-flag write strobe
wr_data_wei_flag  out  KERNEL_SIZE  weight-flag word
wr_req_wei  out  1  weight write strobe
wr_data_wei  out  DATA_WIDTH  weight element
wr_req_act_flag  out  1  act-flag write strobe
wr_data_act_flag  out  IF_WIDTH  act-flag word for current row
wr_req_act  out  IF_WIDTH  per-lane act write enable; equals the act-flag word
wr_data_act  out  IF_WIDTH*DATA_WIDTH  act row data; split to wr_data_act0..15 at top level
mode  out  1  latched cfg_mode
start  out  1  one-cycle launch pulse to mem_controller
busy  out  1  high from accepted load_req until the cycle after start

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs 0; FSM to IDLE; counters and buffers cleared.
  - Applies mid-tile with no partial completion, and no start pulse.
- All write-port outputs are registered. A beat accepted in cycle N appears on the write port in cycle N+1.
- Strobes are high for exactly one cycle per write. Data outputs hold their last value when strobes are low.
- WEI_BEATS = ceil(KERNEL_SIZE/IF_WIDTH) (1 at defaults).
- FSM:
  - IDLE: in_ready=0. load_req → latch mode, busy=1, → WFLAG.
  - WFLAG: in_ready=1. On accept: wr_req_wei_flag=1 next cycle, wr_data_wei_flag=in_data[KERNEL_SIZE-1:0]; → WLOAD.
  - WLOAD: in_ready=1. On accept: store beat in weight buffer → WSER.
  - WSER: in_ready=0. Emits one weight per cycle: wr_req_wei=1, element index w from buffer lane (w mod IF_WIDTH), w ascending from 0.
    - After the last lane of the beat: → WLOAD if more beats remain, else → AFLAG.
    - Overall weight count stops at KERNEL_SIZE; unused lanes of the final beat are discarded.
  - AFLAG: in_ready=1. On accept: store in_data[IF_WIDTH-1:0] in the flag register → ADATA. No write-port output in this state.
  - ADATA: in_ready=1. On accept, in the next cycle:
    - wr_req_act_flag=1;
    - wr_data_act_flag = stored flag;
    - wr_req_act = stored flag;
    - wr_data_act = in_data.
    - Then row counter +1. After row IF_WIDTH-1: → GAP with gap counter = 0; else → AFLAG.
  - GAP: in_ready=0. Count START_GAP cycles after the last act write cycle, then → START. START_GAP=0 goes straight to START.
  - START: start=1 for one cycle; → IDLE. busy clears the following cycle.
- Stalls:
  - in_valid low in any accepting state holds state and outputs (strobes low); there is no timeout.
  - in_data is ignored when in_valid=0.
- An all-zero act flag row is still written: wr_req_act_flag=1, wr_req_act=0.
- load_req while busy has no effect. load_req in the same cycle as the START state's return to IDLE is ignored.
- Minimum tile latency, load_req to start, with in_valid always high and START_GAP=2: 1 + 1 + 1 + 9 + 32 + 2 + 1 = 47 cycles.

Optional Feature:
- Macro: ACT_WEI_LOADER_WEI_SKIP_EN.
- Defined:
  - WSER emits wr_req_wei only for indices w whose stored weight-flag bit w is 1, ascending order.
  - Zero-flag indices consume no cycle.
  - A tile with all-zero weight flag skips WSER output entirely but still consumes all WEI_BEATS beats.
- Undefined: all KERNEL_SIZE weights are emitted regardless of flag.

Test Plan:
- Reset low 2 cycles mid-ADATA at row 5 → all outputs 0 next cycle; no start; a new load_req afterwards completes normally.
- Full tile, defaults, in_valid always high, weight flag 9'h1FF, weights 1..9, act flags 16'h8001 on every row → first wr_req_wei_flag at cycle load_req+2, 9 consecutive wr_req_wei with values 1..9, 16 act writes each with wr_req_act=16'h8001, start exactly 47 cycles after load_req, busy low one cycle after start.
- in_valid deasserted 3 cycles between AFLAG and ADATA of row 7 → in_ready stays 1, no act strobe during the stall, row 7 data correct, start delayed by exactly 3 cycles.
- load_req pulsed again during WSER → ignored; mode keeps the first tile's cfg_mode; exactly one start pulse.
- With WEI_SKIP_EN, weight flag 9'b100010001 → exactly 3 wr_req_wei cycles with weights 0, 4 and 8 in that order; start at cycle 41. Without the macro the same stimulus gives 9 weight writes.
- START_GAP=0, act row flag 16'h0000 → act strobe high with wr_req_act=0; start in the cycle after the final act write.
